quantum_scheduler: RTL and testbench

QUANTUM_SCHEDULER -- requirements
Module: quantum_scheduler

---
 rtl/quantum_scheduler.sv | 108 ++++++++++
 tb/tb_quantum_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/quantum_scheduler.sv
// Round-robin time-slice scheduler: selects a runnable slot, emits context restore/save
// pulses around each slice and counts retired instructions against a programmable quantum.
module quantum_scheduler #(
  parameter int NPROC           = 4,
  parameter int QW              = 16,
  parameter int DEFAULT_QUANTUM = 100,
  localparam int IDW            = $clog2(NPROC)
) (
  input  logic             Clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             setQuantum,
  input  logic [QW-1:0]    quantumValue,
  input  logic             procAdd,
  input  logic [IDW-1:0]   procAddId,
  input  logic             EndOfProcess,
  output logic             ContextChangeBack,
  output logic             ContextChangeTo,
  output logic [IDW-1:0]   currentProc,
  output logic             running,
  output logic [QW-1:0]    quantumLeft,
  output logic [NPROC-1:0] activeMask
);

  typedef enum logic [2:0] {IDLE, SELECT, LOAD, RUN, SAVE} state_t;

  state_t           state, state_next;
  logic [QW-1:0]    quantum;
  logic [IDW-1:0]   proc_next;
  logic [QW-1:0]    left_next;
  logic [NPROC-1:0] mask_next;
  logic             sel_found;
  logic [IDW-1:0]   sel_proc;
  logic [IDW-1:0]   rr_idx;

  // Search starts one past the current slot and wraps back to include it last.
  always_comb begin
    sel_found = 1'b0;
    sel_proc  = currentProc;
    rr_idx    = '0;
    for (int unsigned k = 1; k <= NPROC; k++) begin
      rr_idx = IDW'((32'(currentProc) + k) % NPROC);
      if (!sel_found && activeMask[rr_idx]) begin
        sel_found = 1'b1;
        sel_proc  = rr_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    proc_next  = currentProc;
    left_next  = quantumLeft;
    mask_next  = activeMask;
    case (state)
      IDLE:   if (|activeMask) state_next = SELECT;
      SELECT: begin
        if (sel_found) begin
          state_next = LOAD;
          proc_next  = sel_proc;
        end else begin
          state_next = IDLE;
        end
      end
      LOAD: begin
        state_next = RUN;
        left_next  = quantum;
      end
      RUN: begin
        if (EndOfProcess) begin
          mask_next[currentProc] = 1'b0;
          state_next             = SELECT;
        end else if (tick) begin
          left_next = quantumLeft - QW'(1);
          if (quantumLeft == QW'(1)) state_next = SAVE;
        end
      end
      SAVE:    state_next = SELECT;
      default: state_next = IDLE;
    endcase
    // Applied after the end-of-process clear so a same-cycle add keeps the bit set.
    if (procAdd && (32'(procAddId) < NPROC)) mask_next[procAddId] = 1'b1;
  end

  // Outputs are registered from the next state so pulses line up with the state they mark.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state             <= IDLE;
      currentProc       <= '0;
      activeMask        <= '0;
      quantum           <= QW'(DEFAULT_QUANTUM);
      quantumLeft       <= '0;
      running           <= 1'b0;
      ContextChangeTo   <= 1'b0;
      ContextChangeBack <= 1'b0;
    end else begin
      state             <= state_next;
      currentProc       <= proc_next;
      activeMask        <= mask_next;
      quantumLeft       <= left_next;
      running           <= (state_next == RUN);
      ContextChangeTo   <= (state_next == LOAD);
      ContextChangeBack <= (state_next == SAVE);
      if (setQuantum) quantum <= (quantumValue == '0) ? QW'(1) : quantumValue;
    end
  end

endmodule

// File: tb/tb_quantum_scheduler.sv
// Directed and randomized checks of quantum_scheduler against a behavioural slot model,
// plus a directed round-robin run on an 8-slot, 8-bit-quantum build.
module tb_quantum_scheduler;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        reset, tick, setQuantum, procAdd, EndOfProcess;
  logic [15:0] quantumValue;
  logic [1:0]  procAddId;
  logic        ContextChangeBack, ContextChangeTo, running;
  logic [1:0]  currentProc;
  logic [15:0] quantumLeft;
  logic [3:0]  activeMask;

  logic        tick8, setq8, add8, eop8;
  logic [7:0]  qv8;
  logic [2:0]  id8;
  logic        ccb8, cct8, run8;
  logic [2:0]  cur8;
  logic [7:0]  left8;
  logic [7:0]  mask8;

  quantum_scheduler u_dut (
    .Clock(Clock), .reset(reset), .tick(tick), .setQuantum(setQuantum),
    .quantumValue(quantumValue), .procAdd(procAdd), .procAddId(procAddId),
    .EndOfProcess(EndOfProcess), .ContextChangeBack(ContextChangeBack),
    .ContextChangeTo(ContextChangeTo), .currentProc(currentProc), .running(running),
    .quantumLeft(quantumLeft), .activeMask(activeMask)
  );

  quantum_scheduler #(.NPROC(8), .QW(8)) u_dut8 (
    .Clock(Clock), .reset(reset), .tick(tick8), .setQuantum(setq8),
    .quantumValue(qv8), .procAdd(add8), .procAddId(id8),
    .EndOfProcess(eop8), .ContextChangeBack(ccb8),
    .ContextChangeTo(cct8), .currentProc(cur8), .running(run8),
    .quantumLeft(left8), .activeMask(mask8)
  );

  int n_err    = 0;
  int n_checks = 0;

  // Reference model: phase letter I/S/L/R/B, selected slot, slice remaining, quantum, runnable set.
  byte        m_mode = "I";
  int         m_cur  = 0;
  int         m_left = 0;
  int         m_q    = 100;
  logic [3:0] m_mask = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    tick = 0; setQuantum = 0; quantumValue = '0; procAdd = 0; procAddId = '0; EndOfProcess = 0;
    tick8 = 0; setq8 = 0; qv8 = '0; add8 = 0; id8 = '0; eop8 = 0;
  endtask

  task automatic cyc();
    byte        nm;
    int         nc, nl;
    logic [3:0] nk;
    bit         found;
    nm = m_mode; nc = m_cur; nl = m_left; nk = m_mask; found = 0;
    if (reset) begin
      nm = "I"; nc = 0; nl = 0; nk = '0; m_q = 100;
    end else begin
      if (m_mode == "I") begin
        if (m_mask != 0) nm = "S";
      end else if (m_mode == "S") begin
        for (int k = 1; k <= 4; k++)
          if (!found && m_mask[(m_cur + k) % 4]) begin
            found = 1;
            nc = (m_cur + k) % 4;
          end
        nm = found ? "L" : "I";
      end else if (m_mode == "L") begin
        nm = "R"; nl = m_q;
      end else if (m_mode == "R") begin
        if (EndOfProcess) begin
          nm = "S"; nk[m_cur] = 1'b0;
        end else if (tick) begin
          nl = m_left - 1;
          if (m_left == 1) nm = "B";
        end
      end else begin
        nm = "S";
      end
      if (procAdd) nk[procAddId] = 1'b1;
      if (setQuantum) m_q = (quantumValue == 0) ? 1 : int'(quantumValue);
    end
    @(posedge Clock);
    #1;
    m_mode = nm; m_cur = nc; m_left = nl; m_mask = nk;
    check("model_currentProc", currentProc, m_cur);
    check("model_activeMask", activeMask, m_mask);
    check("model_quantumLeft", quantumLeft, m_left);
    check("model_running", running, m_mode == "R");
    check("model_ContextChangeTo", ContextChangeTo, m_mode == "L");
    check("model_ContextChangeBack", ContextChangeBack, m_mode == "B");
  endtask

  task automatic wait_running(input string tag);
    for (int k = 0; k < 10; k++) begin
      if (running === 1'b1) break;
      cyc();
    end
    check({tag, "_running"}, running, 1);
  endtask

  task automatic count_slice(output int n);
    n = 0;
    tick = 1;
    for (int k = 0; k < 40; k++) begin
      if (running === 1'b1) n++;
      cyc();
      if (ContextChangeBack === 1'b1) break;
    end
    tick = 0;
  endtask

  initial begin : main
    int seq[$];
    int slices[$];
    int rc, n, pulses;
    bit found;
    int exp37[3];
    int exp8[3];

    idle();
    reset = 1;
    cyc(); cyc();
    check("rst_currentProc", currentProc, 0);
    check("rst_activeMask", activeMask, 0);
    check("rst_quantumLeft", quantumLeft, 0);
    check("rst_running", running, 0);
    check("rst_pulses", {ContextChangeTo, ContextChangeBack}, 0);

    reset = 0; procAdd = 1; procAddId = 1; cyc(); procAdd = 0;
    wait_running("dq");
    check("default_quantum", quantumLeft, 100);

    // Single slot 2, quantum 3, five ticks across expiry.
    reset = 1; cyc(); reset = 0;
    setQuantum = 1; quantumValue = 3; procAdd = 1; procAddId = 2; cyc();
    setQuantum = 0; procAdd = 0;
    cyc();
    cyc();
    check("r36_to", ContextChangeTo, 1);
    check("r36_to_proc", currentProc, 2);
    cyc();
    check("r36_run", running, 1);
    check("r36_left", quantumLeft, 3);
    tick = 1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      if (i == 3) check("r36_back", ContextChangeBack, 1);
    end
    check("r36_to2", ContextChangeTo, 1);
    check("r36_to2_proc", currentProc, 2);
    tick = 0; cyc();
    check("r36_left2", quantumLeft, 3);

    // Slots 0,1,3 with quantum 2 and continuous ticks.
    reset = 1; cyc(); reset = 0;
    setQuantum = 1; quantumValue = 2; procAdd = 1; procAddId = 0; cyc();
    setQuantum = 0; procAdd = 0;
    cyc();
    procAdd = 1; procAddId = 1; tick = 1; cyc();
    check("r37_to0", ContextChangeTo, 1);
    check("r37_proc0", currentProc, 0);
    procAddId = 3; cyc(); procAdd = 0;
    rc = 0;
    for (int k = 0; k < 60 && seq.size() < 3; k++) begin
      if (running === 1'b1 && tick) rc++;
      cyc();
      if (ContextChangeBack === 1'b1) begin slices.push_back(rc); rc = 0; end
      if (ContextChangeTo === 1'b1) seq.push_back(int'(currentProc));
    end
    exp37 = '{1, 3, 0};
    check("r37_pulse_count", seq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("r37_proc_seq", (i < seq.size()) ? seq[i] : -1, exp37[i]);
      check("r37_slice_len", (i < slices.size()) ? slices[i] : -1, 2);
    end
    tick = 0;

    // End-of-process and expiring tick in the same cycle.
    reset = 1; cyc(); reset = 0;
    setQuantum = 1; quantumValue = 2; procAdd = 1; procAddId = 1; cyc();
    setQuantum = 0; procAddId = 2; cyc(); procAdd = 0;
    wait_running("r38");
    check("r38_proc1", currentProc, 1);
    tick = 1; cyc();
    EndOfProcess = 1; cyc(); tick = 0; EndOfProcess = 0;
    check("r38_no_back", ContextChangeBack, 0);
    check("r38_mask", activeMask, 4'b0100);
    cyc();
    check("r38_no_back2", ContextChangeBack, 0);
    check("r38_to", ContextChangeTo, 1);
    check("r38_to_proc", currentProc, 2);

    // Quantum updates land on the next load only; zero is stored as one.
    reset = 1; cyc(); reset = 0;
    setQuantum = 1; quantumValue = 7; procAdd = 1; procAddId = 0; cyc();
    setQuantum = 0; procAdd = 0;
    wait_running("r39");
    check("r39_left7", quantumLeft, 7);
    setQuantum = 1; quantumValue = 5; cyc(); setQuantum = 0;
    check("r39_left7_hold", quantumLeft, 7);
    count_slice(n);
    check("r39_slice7", n, 7);
    cyc();
    check("r39_sel_run", running, 0);
    check("r39_sel_to", ContextChangeTo, 0);
    cyc();
    check("r39_reload_to", ContextChangeTo, 1);
    check("r39_reload_proc", currentProc, 0);
    setQuantum = 1; quantumValue = 0; cyc(); setQuantum = 0;
    check("r39_left5", quantumLeft, 5);
    count_slice(n);
    check("r39_slice5", n, 5);
    wait_running("r39b");
    check("r39_left1", quantumLeft, 1);

    // Last process ends, scheduler idles, then the slot is re-added.
    reset = 1; cyc(); reset = 0;
    procAdd = 1; procAddId = 2; cyc(); procAdd = 0;
    wait_running("r40");
    EndOfProcess = 1; cyc(); EndOfProcess = 0;
    check("r40_run0", running, 0);
    check("r40_mask0", activeMask, 0);
    check("r40_no_back", ContextChangeBack, 0);
    cyc(); cyc(); cyc();
    check("r40_idle_run", running, 0);
    check("r40_idle_pulses", {ContextChangeTo, ContextChangeBack}, 0);
    procAdd = 1; procAddId = 2; cyc(); procAdd = 0;
    found = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (ContextChangeTo === 1'b1) begin found = 1; break; end
    end
    check("r40_readd_to", found, 1);
    check("r40_readd_proc", currentProc, 2);

    // Reset alongside an expiring tick, then reset while the save pulse is up.
    reset = 1; cyc(); reset = 0;
    setQuantum = 1; quantumValue = 1; procAdd = 1; procAddId = 0; cyc();
    setQuantum = 0; procAdd = 0;
    wait_running("r41");
    tick = 1; reset = 1; cyc(); tick = 0;
    check("r41_no_back", ContextChangeBack, 0);
    check("r41_cur", currentProc, 0);
    check("r41_mask", activeMask, 0);
    check("r41_left", quantumLeft, 0);
    check("r41_run", running, 0);
    reset = 0; pulses = 0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      pulses += int'(ContextChangeTo) + int'(ContextChangeBack);
    end
    check("r41_quiet", pulses, 0);
    setQuantum = 1; quantumValue = 1; procAdd = 1; procAddId = 1; cyc();
    setQuantum = 0; procAdd = 0;
    wait_running("r41b");
    tick = 1; cyc(); tick = 0;
    reset = 1; cyc(); reset = 0;
    check("r41b_pulses", {ContextChangeTo, ContextChangeBack}, 0);
    check("r41b_mask", activeMask, 0);
    check("r41b_left", quantumLeft, 0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      pulses += int'(ContextChangeTo) + int'(ContextChangeBack);
    end
    check("r41b_quiet", pulses, 0);

    // 8-slot build: slots 0 and 7 alternate with quantum 2.
    reset = 1; cyc(); reset = 0;
    check("n8_rst_mask", mask8, 0);
    setq8 = 1; qv8 = 2; add8 = 1; id8 = 0; cyc();
    setq8 = 0; add8 = 0;
    cyc();
    add8 = 1; id8 = 7; tick8 = 1; cyc(); add8 = 0;
    check("n8_to0", cct8, 1);
    check("n8_proc0", cur8, 0);
    seq.delete(); slices.delete(); rc = 0;
    for (int k = 0; k < 60 && seq.size() < 3; k++) begin
      if (run8 === 1'b1) rc++;
      cyc();
      if (ccb8 === 1'b1) begin slices.push_back(rc); rc = 0; end
      if (cct8 === 1'b1) seq.push_back(int'(cur8));
    end
    exp8 = '{7, 0, 7};
    check("n8_pulse_count", seq.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("n8_proc_seq", (i < seq.size()) ? seq[i] : -1, exp8[i]);
      check("n8_slice_len", (i < slices.size()) ? slices[i] : -1, 2);
    end
    tick8 = 0;

    // Randomized traffic against the model.
    reset = 1; cyc(); reset = 0;
    for (int k = 0; k < 400; k++) begin
      tick         = ($urandom_range(0, 9) < 7);
      EndOfProcess = ($urandom_range(0, 19) == 0);
      procAdd      = ($urandom_range(0, 4) == 0);
      procAddId    = 2'($urandom_range(0, 3));
      setQuantum   = ($urandom_range(0, 14) == 0);
      quantumValue = 16'($urandom_range(0, 5));
      reset        = ($urandom_range(0, 99) == 0);
      cyc();
    end
    idle(); reset = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
